sram_shared_arbiter: RTL and testbench

Shares one single-port, latency-1 SRAM macro among `NumReq` requesters in the memory subsystem. It sits between the requesters' req/gnt/rvalid interfaces and the macro port, and grants round-robin. It returns one response per granted access. An optional post-reset sequencer zero-fills the array before any requester is served.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_rr.sv | 31 +++
 rtl/sram_shared_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_shared_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and width helpers for sram_shared_arbiter
package sram_arb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Word address width; a single-word array still needs one address bit
  function automatic int addr_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  // Number of byte enables, rounding a partial top byte up
  function automatic int be_width(input int data_width, input int byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// rtl/sram_arb_rr.sv - round-robin pick starting at a rotating pointer
module sram_arb_rr #(
  parameter int NumReq   = 2,
  parameter int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] rr_q,
  output logic [NumReq-1:0]   gnt,
  output logic [IdxWidth-1:0] idx
);

  logic        found;
  int unsigned cand;

  // Scan upward from rr_q modulo NumReq; the first asserted request wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NumReq; i++) begin
      cand = (int'(rr_q) + i) % NumReq;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/sram_shared_arbiter.sv
// rtl/sram_shared_arbiter.sv - round-robin sharing of one latency-1 SRAM port; SRAM_ARB_INIT_EN adds a post-reset zero-fill
module sram_shared_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NumReq    = 2,
  parameter int NumWords  = 512,
  parameter int DataWidth = 32,
  parameter int ByteWidth = 8,
  parameter int AddrWidth = addr_width(NumWords),
  parameter int BeWidth   = be_width(DataWidth, ByteWidth)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*BeWidth-1:0]     be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          init_done_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [AddrWidth-1:0]          sram_addr_o,
  output logic [DataWidth-1:0]          sram_wdata_o,
  output logic [BeWidth-1:0]            sram_be_o,
  input  logic [DataWidth-1:0]          sram_rdata_i
);

  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] rr_idx;
  logic [IdxWidth-1:0] rr_next;
  logic [NumReq-1:0]   rr_gnt;
  logic [NumReq-1:0]   rvalid_q;

  sram_arb_rr #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr (
    .req  (req_i),
    .rr_q (rr_q),
    .gnt  (rr_gnt),
    .idx  (rr_idx)
  );

  assign rr_next = (rr_idx == IdxWidth'(NumReq - 1)) ? '0 : rr_idx + 1'b1;

`ifdef SRAM_ARB_INIT_EN
  state_e               state_q;
  logic [AddrWidth-1:0] cnt_q;
  logic                 init_done_q;

  // Zero-fill sequencer: one word per cycle, then hand the port to requesters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == AddrWidth'(NumWords - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign init_done_o = init_done_q;
`else
  assign init_done_o = 1'b1;
`endif

  // Macro port: zero-fill writes during INIT, otherwise the round-robin winner
  always_comb begin
    gnt_o        = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (rst_i) begin
      gnt_o = '0;
`ifdef SRAM_ARB_INIT_EN
    end else if (state_q == INIT) begin
      sram_req_o  = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = cnt_q;
      sram_be_o   = '1;
`endif
    end else begin
      gnt_o        = rr_gnt;
      sram_req_o   = |req_i;
      sram_we_o    = we_i[rr_idx];
      sram_addr_o  = addr_i[int'(rr_idx)*AddrWidth +: AddrWidth];
      sram_wdata_o = wdata_i[int'(rr_idx)*DataWidth +: DataWidth];
      sram_be_o    = be_i[int'(rr_idx)*BeWidth +: BeWidth];
    end
  end

  // Rotate priority past each winner and delay the grant into the response strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
      if (|gnt_o) begin
        rr_q <= rr_next;
      end
    end
  end

  // A response still in flight when reset hits is never presented
  assign rvalid_o = rst_i ? '0 : rvalid_q;
  assign rdata_o  = sram_rdata_i;

endmodule

// File: tb/tb_sram_shared_arbiter.sv
// tb/tb_sram_shared_arbiter.sv - scoreboard bench for sram_shared_arbiter with a latency-1 SRAM model
module tb_sram_shared_arbiter;

  localparam int NumReq = 2;
  localparam int NumWords = 512;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int BW = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NumReq-1:0]    req_i;
  logic [NumReq-1:0]    we_i;
  logic [NumReq*AW-1:0] addr_i;
  logic [NumReq*DW-1:0] wdata_i;
  logic [NumReq*BW-1:0] be_i;
  logic [NumReq-1:0]    gnt_o;
  logic [NumReq-1:0]    rvalid_o;
  logic [DW-1:0]        rdata_o;
  logic                 init_done_o;
  logic                 sram_req_o;
  logic                 sram_we_o;
  logic [AW-1:0]        sram_addr_o;
  logic [DW-1:0]        sram_wdata_o;
  logic [BW-1:0]        sram_be_o;
  logic [DW-1:0]        sram_rdata_q;

  typedef struct {
    logic [1:0]  rv;
    bit          rd;
    logic [31:0] data;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    failures = 0;

  logic [DW-1:0] mem [NumWords];
  bit            mem_ready = 1'b0;

  sram_shared_arbiter #(
    .NumReq    (NumReq),
    .NumWords  (NumWords),
    .DataWidth (DW),
    .ByteWidth (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .be_i         (be_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .init_done_o  (init_done_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_q)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Latency-1 SRAM model, pre-filled with a non-zero pattern
  always @(posedge clk_i) begin
    if (!mem_ready) begin
      for (int i = 0; i < NumWords; i++) mem[i] <= 32'hA5A5_A5A5;
      mem_ready <= 1'b1;
    end else if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < BW; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_q <= mem[sram_addr_o];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected response
  always @(negedge clk_i) begin
    if (rvalid_o !== 2'b00) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {62'd0, rvalid_o}, 64'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("rvalid", {62'd0, rvalid_o}, {62'd0, e.rv});
        if (e.rd) check("rdata", {32'd0, rdata_o}, {32'd0, e.data});
      end
    end
  end

  task automatic expect_resp(input logic [1:0] rv, input bit rd, input logic [31:0] d);
    resp_t e;
    e.rv = rv;
    e.rd = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input bit w, input logic [8:0] a, input logic [31:0] d, input logic [3:0] b);
    req_i[k] = 1'b1;
    we_i[k] = w;
    addr_i[k*AW +: AW] = a;
    wdata_i[k*DW +: DW] = d;
    be_i[k*BW +: BW] = b;
  endtask

  task automatic single(input int k, input bit w, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_rd, input string name);
    @(posedge clk_i); #1;
    req_i = '0;
    set_req(k, w, a, d, b);
    #1;
    check({name, "_gnt"}, {62'd0, gnt_o}, {62'd0, 2'b01 << k});
    expect_resp(2'b01 << k, !w, exp_rd);
    @(posedge clk_i); #1;
    req_i = '0;
  endtask

`ifdef SRAM_ARB_INIT_EN
  task automatic init_phase(input int abort_at);
    int errs = 0;
    req_i = '0;
    set_req(0, 1'b0, 9'h1FF, 32'd0, 4'hF);
    set_req(1, 1'b0, 9'h1FF, 32'd0, 4'hF);
    for (int j = 0; j < NumWords; j++) begin
      #1;
      if (j == abort_at) begin
        check("midinit_addr", {55'd0, sram_addr_o}, 64'(j));
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        return;
      end
      if (!(sram_req_o === 1'b1 && sram_we_o === 1'b1 && sram_addr_o === AW'(j) &&
            sram_wdata_o === 32'd0 && sram_be_o === 4'hF && gnt_o === 2'b00 && init_done_o === 1'b0))
        errs++;
      @(posedge clk_i); #1;
    end
    check("init_seq_errors", 64'(errs), 64'd0);
    #1;
    check("init_done_rise", {63'd0, init_done_o}, 64'd1);
    check("first_run_gnt", {62'd0, gnt_o}, 64'h1);
    expect_resp(2'b01, 1'b1, 32'd0);
    @(posedge clk_i); #2;
    check("second_run_gnt", {62'd0, gnt_o}, 64'h2);
    expect_resp(2'b10, 1'b1, 32'd0);
    @(posedge clk_i); #1;
    req_i = '0;
  endtask
`endif

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    rst_i = 1'b1;
    req_i = '0;
    we_i = '0;
    addr_i = '0;
    wdata_i = '0;
    be_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    set_req(0, 1'b0, 9'h0, 32'd0, 4'hF);
    set_req(1, 1'b0, 9'h1, 32'd0, 4'hF);
    #1;
    check("rst_gnt", {62'd0, gnt_o}, 64'd0);
    check("rst_rvalid", {62'd0, rvalid_o}, 64'd0);
    check("rst_sram_req", {63'd0, sram_req_o}, 64'd0);
`ifdef SRAM_ARB_INIT_EN
    check("rst_init_done", {63'd0, init_done_o}, 64'd0);
`else
    check("rst_init_done", {63'd0, init_done_o}, 64'd1);
`endif
    req_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

`ifdef SRAM_ARB_INIT_EN
    init_phase(100);
    init_phase(-1);
`else
    set_req(0, 1'b1, 9'h1FF, 32'd0, 4'hF);
    #1;
    check("first_cycle_gnt", {62'd0, gnt_o}, 64'h1);
    expect_resp(2'b01, 1'b0, 32'd0);
    @(posedge clk_i); #1;
    req_i = '0;
`endif

    single(0, 1'b1, 9'h010, 32'hDEAD_BEEF, 4'hF, 32'd0, "wr10");
    single(0, 1'b0, 9'h010, 32'd0, 4'hF, 32'hDEAD_BEEF, "rd10");

    single(0, 1'b1, 9'h020, 32'h2020_2020, 4'hF, 32'd0, "wr20");
    single(1, 1'b1, 9'h021, 32'h2121_2121, 4'hF, 32'd0, "wr21");
    @(posedge clk_i); #1;
    set_req(0, 1'b0, 9'h020, 32'd0, 4'hF);
    set_req(1, 1'b0, 9'h021, 32'd0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i % 2 == 0) begin
        check("contend_gnt", {62'd0, gnt_o}, 64'h1);
        expect_resp(2'b01, 1'b1, 32'h2020_2020);
      end else begin
        check("contend_gnt", {62'd0, gnt_o}, 64'h2);
        expect_resp(2'b10, 1'b1, 32'h2121_2121);
      end
      @(posedge clk_i); #1;
    end
    req_i = '0;

    single(0, 1'b1, 9'h030, 32'h1122_3344, 4'hF, 32'd0, "be_full");
    single(1, 1'b1, 9'h030, 32'h0000_AB00, 4'b0010, 32'd0, "be_part");
    single(0, 1'b0, 9'h030, 32'd0, 4'hF, 32'h1122_AB44, "be_rd");

    @(posedge clk_i); #1;
    set_req(0, 1'b0, 9'h010, 32'd0, 4'hF);
    #1;
    check("inflight_gnt", {62'd0, gnt_o}, 64'h1);
    @(posedge clk_i); #1;
    req_i = '0;
    rst_i = 1'b1;
    #1;
    check("inflight_rvalid", {62'd0, rvalid_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
`ifdef SRAM_ARB_INIT_EN
    init_phase(-1);
`else
    set_req(0, 1'b0, 9'h020, 32'd0, 4'hF);
    set_req(1, 1'b0, 9'h021, 32'd0, 4'hF);
    #1;
    check("post_rst_gnt0", {62'd0, gnt_o}, 64'h1);
    expect_resp(2'b01, 1'b1, 32'h2020_2020);
    @(posedge clk_i); #2;
    check("post_rst_gnt1", {62'd0, gnt_o}, 64'h2);
    expect_resp(2'b10, 1'b1, 32'h2121_2121);
    @(posedge clk_i); #1;
    req_i = '0;
`endif

    repeat (3) @(posedge clk_i);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
